key_capture: RTL and testbench
==============================

# key_capture

Upstream input stage for the 4-to-2 encoder. It samples four raw, bouncing key lines and debounces them. It then resolves simultaneous presses by fixed priority and presents one registered one-hot vector (a, b, c, d) to the encoder's inputs, with a valid/ack handshake. Exactly one output is high while valid is high, so the downstream encoder always sees legal one-hot input.

## Interface
Parameters:
- DB_CYCLES, default 4: consecutive identical synchronized samples required to accept a press or a release. Legal range is 1..255.

Ports:
- clk, input, 1: single clock; all state is updated on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- key_in, input, 4: raw asynchronous key lines, active high. key_in[3]=a, [2]=b, [1]=c, [0]=d.
- ack, input, 1: consumer has taken the current code. Sampled only while valid=1.
- a, b, c, d, output, 1 each: registered one-hot key code, or all zero.
- valid, output, 1: registered; high while a/b/c/d hold a captured key.

## Operation
- The synchronizer produces s[3:0] from key_in; its depth L is set under Configuration.
- Internal state: cand[3:0], cnt (width $clog2(DB_CYCLES+1)), and a 2-bit FSM.
- IDLE:
  - If s≠0: cand←s, cnt←1, go to DEBOUNCE.
  - If DB_CYCLES=1, go directly to capture instead.
- DEBOUNCE:
  - s==cand and cnt==DB_CYCLES-1: capture and go to HOLD.
  - s==cand otherwise: cnt++.
  - s==0: go to IDLE, cnt←0.
  - Any other s: cand←s, cnt←1; the debounce restarts.
- Capture: {a,b,c,d} ← priority one-hot of cand (a > b > c > d), and valid←1.
- HOLD:
  - Outputs are frozen; key_in changes are ignored.
  - ack=1: valid and a..d clear on the same edge, cnt←0, go to RELEASE.
- RELEASE:
  - s==0: cnt++. When cnt==DB_CYCLES-1 and s==0, go to IDLE.
  - Any s≠0: cnt←0.
  - No new capture is possible until all keys have been stably released.
- ack outside HOLD has no effect.
- Reset, asynchronous and at any point including mid-debounce or in HOLD:
  - FSM=IDLE; cand, cnt and synchronizer flops = 0.
  - valid=0 and a=b=c=d=0 immediately.
  - No partial capture survives.

## Timing
- All outputs are registered; there is no combinational path from key_in or ack to any output.
- Press latency: take key_in stable before edge 1. valid rises at edge L+DB_CYCLES.
  - 6 edges with defaults and the synchronizer macro defined.
  - 5 edges without the macro.
- ack sampled high at edge n: valid=0 after edge n.
- Release latency: the earliest re-arm (FSM in IDLE) is L+DB_CYCLES edges after the keys go low, counted from the later of the ack edge and the key release.
- A bounce shorter than DB_CYCLES samples never produces valid.
- Each press yields exactly one valid pulse sequence. A key held across ack does not re-trigger.

## Configuration
- KEY_CAPTURE_SYNC2_EN defined: two-flop synchronizer per key line, L=2.
- Not defined: single sampling flop, L=1. Use this only when key_in is already synchronous to clk.
- All other behaviour is identical.

## Structure
- Shared package key_pkg holds:
  - FSM state encodings: IDLE=0, DEBOUNCE=1, HOLD=2, RELEASE=3.
  - Key bit indices KEY_A=3 .. KEY_D=0.
  - Default DB_CYCLES.
- One sub-module, key_sync: a parameterized per-bit synchronizer whose depth follows KEY_CAPTURE_SYNC2_EN.
- The priority resolve is a function inside key_capture.

## Test plan
- Reset: hold rst_n=0 with key_in=4'b1111 → valid=0 and a..d=0 throughout. Release reset with key_in=0 → outputs stay 0.
- Clean press: key_in=4'b0010 held (defaults, SYNC2) → valid=1 and c=1 at edge 6. Pulse ack → valid=0 next edge. Hold the key for 20 more cycles → no second valid.
- Bounce: key_in toggles 0010/0000 every 2 cycles for 20 cycles, then holds 0010 → valid only DB_CYCLES+L edges after the last toggle.
- Simultaneous keys: key_in=4'b0101 held → b=1 only, a=c=d=0. Change to 4'b1101 mid-debounce → count restarts; a=1 at capture.
- Reset mid-operation: assert rst_n=0 in HOLD with valid=1 → valid and a..d drop asynchronously. After reset, a still-held key is re-debounced from IDLE.
- Macro off: repeat the clean press → valid at edge 5.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the key_capture input stage.
// FSM state encodings, key bit positions and the default debounce length.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } key_state_e;

  localparam int NUM_KEYS = 4;

  // Bit positions within key_in / the one-hot code: a is the MSB.
  localparam int KEY_A = 3;
  localparam int KEY_B = 2;
  localparam int KEY_C = 1;
  localparam int KEY_D = 0;

  localparam int DB_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/key_sync.sv
// key_sync: per-bit synchronizer for the raw key lines.
// Depth is two flops when KEY_CAPTURE_SYNC2_EN is defined, otherwise a single
// sampling flop (only for key lines already synchronous to clk).
module key_sync
  import key_pkg::*;
#(
  parameter int W = NUM_KEYS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

`ifdef KEY_CAPTURE_SYNC2_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [STAGES-1:0][W-1:0] stage_q;

  // Shift chain; stage 0 samples the raw lines, the last stage is the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/key_capture.sv
// key_capture: debounces four raw key lines, resolves simultaneous presses by
// fixed priority (a > b > c > d) and presents a registered one-hot code with a
// valid/ack handshake. Synchronizer depth is selected by KEY_CAPTURE_SYNC2_EN.
//
// state    | meaning
// IDLE     | no key seen; waiting for any synchronized key high
// DEBOUNCE | counting consecutive identical samples of cand
// HOLD     | code captured, valid high, outputs frozen until ack
// RELEASE  | waiting for all keys to read low for DB_CYCLES samples
module key_capture
  import key_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic                ack,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                d,
  output logic                valid
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  // Highest-priority set key wins; result is one-hot or zero.
  function automatic logic [NUM_KEYS-1:0] prio_onehot(input logic [NUM_KEYS-1:0] k);
    logic [NUM_KEYS-1:0] r;
    r = '0;
    if (k[KEY_A])      r[KEY_A] = 1'b1;
    else if (k[KEY_B]) r[KEY_B] = 1'b1;
    else if (k[KEY_C]) r[KEY_C] = 1'b1;
    else if (k[KEY_D]) r[KEY_D] = 1'b1;
    return r;
  endfunction

  logic [NUM_KEYS-1:0] s;
  logic [NUM_KEYS-1:0] cand_q;
  logic [CW-1:0]       cnt_q;
  key_state_e          state_q;
  logic [NUM_KEYS-1:0] code_q;
  logic                valid_q;

  key_sync #(
    .W (NUM_KEYS)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (key_in),
    .q_o   (s)
  );

  // Debounce / capture / release sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s != '0) begin
            cand_q <= s;
            if (DB_CYCLES == 1) begin
              // A single sample is already stable enough: capture immediately.
              code_q  <= prio_onehot(s);
              valid_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_HOLD;
            end else begin
              cnt_q   <= CNT_ONE;
              state_q <= ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (s == cand_q) begin
            if (cnt_q == CNT_LAST) begin
              code_q  <= prio_onehot(cand_q);
              valid_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= ST_HOLD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (s == '0) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            // Key pattern changed while still bouncing: start over on the new one.
            cand_q <= s;
            cnt_q  <= CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (ack) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // Re-arm only after every key has read low for DB_CYCLES samples.
          if (s == '0) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              cand_q  <= '0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign a     = code_q[KEY_A];
  assign b     = code_q[KEY_B];
  assign c     = code_q[KEY_C];
  assign d     = code_q[KEY_D];
  assign valid = valid_q;

endmodule

// File: tb/tb_key_capture.sv
// tb_key_capture: directed test of key_capture with default DB_CYCLES.
// Expected press latency is L + DB_CYCLES edges, with L set by KEY_CAPTURE_SYNC2_EN.
module tb_key_capture;

  localparam int DB = 4;
`ifdef KEY_CAPTURE_SYNC2_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int LAT = L + DB;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic       ack;
  logic       a, b, c, d, valid;
  logic [3:0] code;

  int n_cmp = 0;
  int n_bad = 0;

  assign code = {a, b, c, d};

  key_capture #(.DB_CYCLES(DB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in),
    .ack    (ack),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic [3:0] k);
    @(negedge clk);
    key_in = k;
  endtask

  // Waits through a press of LAT edges, expecting valid only on the last edge.
  task automatic press_window(input string name, input logic [3:0] exp_code);
    for (int e = 1; e <= LAT; e++) begin
      tick();
      n_cmp++;
      if (e < LAT) begin
        if (valid !== 1'b0) begin
          n_bad++;
          $display("FAIL %s early_valid edge=%0d got=%b want=0", name, e, valid);
        end
      end else begin
        if (valid !== 1'b1 || code !== exp_code) begin
          n_bad++;
          $display("FAIL %s capture edge=%0d got valid=%b code=%b want valid=1 code=%b",
                   name, e, valid, code, exp_code);
        end
      end
    end
  endtask

  // Acks the held code, checks it clears on that edge, then releases all keys.
  task automatic ack_and_release(input string name);
    @(negedge clk);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || code !== 4'b0000) begin
      n_bad++;
      $display("FAIL %s ack_clear got valid=%b code=%b want valid=0 code=0000", name, valid, code);
    end
    set_key(4'b0000);
    repeat (LAT + 3) tick();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    key_in = 4'b1111;
    ack    = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (valid !== 1'b0 || code !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d got valid=%b code=%b want 0/0000", i, valid, code);
      end
    end
    @(negedge clk);
    key_in = 4'b0000;
    rst_n  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (valid !== 1'b0 || code !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got valid=%b code=%b want 0/0000", i, valid, code);
      end
    end
  endtask

  task automatic test_clean_press();
    set_key(4'b0010);
    press_window("clean_press", 4'b0010);
    @(negedge clk);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || code !== 4'b0000) begin
      n_bad++;
      $display("FAIL clean_ack got valid=%b code=%b want 0/0000", valid, code);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (valid !== 1'b0) begin
        n_bad++;
        $display("FAIL clean_no_retrigger cyc=%0d got valid=%b want 0", i, valid);
      end
    end
    set_key(4'b0000);
    repeat (LAT + 3) tick();
  endtask

  task automatic test_bounce();
    for (int p = 0; p < 5; p++) begin
      set_key(4'b0010);
      for (int i = 0; i < 2; i++) begin
        tick();
        n_cmp++;
        if (valid !== 1'b0) begin
          n_bad++;
          $display("FAIL bounce_hi p=%0d i=%0d got valid=%b want 0", p, i, valid);
        end
      end
      set_key(4'b0000);
      for (int i = 0; i < 2; i++) begin
        tick();
        n_cmp++;
        if (valid !== 1'b0) begin
          n_bad++;
          $display("FAIL bounce_lo p=%0d i=%0d got valid=%b want 0", p, i, valid);
        end
      end
    end
    set_key(4'b0010);
    press_window("bounce_settle", 4'b0010);
    ack_and_release("bounce");
  endtask

  task automatic test_simultaneous();
    set_key(4'b0101);
    press_window("simul_0101", 4'b0100);
    ack_and_release("simul_0101");
    // Change pattern two edges into the debounce; the count restarts on 1101.
    set_key(4'b0101);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (valid !== 1'b0) begin
        n_bad++;
        $display("FAIL simul_pre i=%0d got valid=%b want 0", i, valid);
      end
    end
    set_key(4'b1101);
    press_window("simul_1101", 4'b1000);
    ack_and_release("simul_1101");
  endtask

  task automatic test_reset_mid();
    set_key(4'b0001);
    press_window("midrst_press", 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || code !== 4'b0000) begin
      n_bad++;
      $display("FAIL midrst_async got valid=%b code=%b want 0/0000", valid, code);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    press_window("midrst_redebounce", 4'b0001);
    ack_and_release("midrst");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
